// File: rtl/lsu_master.sv
// ---------------------------------------------------------------------------
// lsu_master -- load/store initiator between the core and the data memory
//
// Takes one load or store request at a time from the core, drives the
// single-port data memory, and returns the result on a valid/ready response.
// Aligned accesses go to memory as a single beat of the original op, and the
// memory does the extension itself. A misaligned access (LW/SW with
// addr[1:0]!=0, or LH/LHU/SH with addr[1:0]==3) is split into one byte beat
// per byte (LBU for loads, SB for stores). Load bytes are gathered in an
// assembly register and extended here. Addresses of later beats wrap modulo
// 2^Addr_bits.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake (ready only while IDLE)
//   req_op/addr/wdata      operation, byte address, right-aligned store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              extended load data (0 for stores)
//   rsp_err                misaligned-trap flag
//   mem_rd_wr/addr/din     memory command, byte address, write data
//   mem_dout               memory read data (combinational from mem_addr)
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   When defined, misaligned requests skip the memory and respond at once
//   with rsp_err=1 and rsp_rdata=0. When undefined, they are split into
//   byte beats and rsp_err is tied to 0.
// ---------------------------------------------------------------------------

package controls;
   typedef enum logic [3:0] {
      LW  = 4'd0,
      LH  = 4'd1,
      LHU = 4'd2,
      LB  = 4'd3,
      LBU = 4'd4,
      SW  = 4'd5,
      SH  = 4'd6,
      SB  = 4'd7
   } mem_op;
endpackage

module lsu_master
   import controls::*;
#(
   parameter int Word_size = 32,
   parameter int Addr_bits = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  mem_op                req_op,
   input  logic [Addr_bits-1:0] req_addr,
   input  logic [Word_size-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [Word_size-1:0] rsp_rdata,
   output logic                 rsp_err,
   output mem_op                mem_rd_wr,
   output logic [Addr_bits-1:0] mem_addr,
   output logic [Word_size-1:0] mem_din,
   input  logic [Word_size-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;

   mem_op                op_q;
   logic [Addr_bits-1:0] addr_q;
   logic [Word_size-1:0] wdata_q;
   logic [Word_size-1:0] asm_q;
   logic [Word_size-1:0] rdata_q;
   logic                 split_q;
   logic [1:0]           beat_q;
   logic [1:0]           last_beat_q;

   // Unsupported encodings fold to LW so they behave as a plain read.
   function automatic mem_op norm_op(input mem_op op);
      case (op)
         LW, LH, LHU, LB, LBU, SW, SH, SB: norm_op = op;
         default:                          norm_op = LW;
      endcase
   endfunction

   function automatic logic is_store(input mem_op op);
      is_store = (op == SW) || (op == SH) || (op == SB);
   endfunction

   function automatic logic is_word(input mem_op op);
      is_word = (op == LW) || (op == SW);
   endfunction

   function automatic logic is_half(input mem_op op);
      is_half = (op == LH) || (op == LHU) || (op == SH);
   endfunction

   mem_op req_op_n;
   logic  req_misaligned;
   logic  last_beat;

   // Request decode: normalised op and the misalignment rule per access size.
   always_comb begin
      req_op_n       = norm_op(req_op);
      req_misaligned = 1'b0;
      if (is_word(req_op_n)) begin
         req_misaligned = (req_addr[1:0] != 2'b00);
      end else if (is_half(req_op_n)) begin
         req_misaligned = (req_addr[1:0] == 2'b11);
      end
      last_beat = (beat_q == last_beat_q);
   end

   logic [7:0]           wbyte;
   logic [Word_size-1:0] assembled;
   logic [Word_size-1:0] final_rdata;

   // Byte k of the store data for misaligned beat k, the assembly register
   // with the byte arriving this beat merged in, and the response value that
   // is registered when the last beat completes.
   always_comb begin
      wbyte     = 8'h00;
      assembled = asm_q;
      case (beat_q)
         2'd0: begin
            wbyte           = wdata_q[7:0];
            assembled[7:0]  = mem_dout[7:0];
         end
         2'd1: begin
            wbyte           = wdata_q[15:8];
            assembled[15:8] = mem_dout[7:0];
         end
         2'd2: begin
            wbyte            = wdata_q[23:16];
            assembled[23:16] = mem_dout[7:0];
         end
         default: begin
            wbyte            = wdata_q[31:24];
            assembled[31:24] = mem_dout[7:0];
         end
      endcase

      final_rdata = '0;
      if (!is_store(op_q)) begin
         if (!split_q) begin
            final_rdata = mem_dout;
         end else begin
            case (op_q)
               LH:      final_rdata = {{(Word_size-16){assembled[15]}}, assembled[15:0]};
               LHU:     final_rdata = {{(Word_size-16){1'b0}}, assembled[15:0]};
               default: final_rdata = assembled;
            endcase
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and memory/handshake drive. Outside a beat the memory sees a
   // harmless LW at address 0, so it never writes by accident.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_rd_wr  = LW;
      mem_addr   = '0;
      mem_din    = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (req_misaligned) begin
                  state_next = RESP;
               end else begin
                  state_next = BEAT;
               end
`else
               state_next = BEAT;
`endif
            end
         end
         BEAT: begin
            if (split_q) begin
               mem_addr     = addr_q + Addr_bits'(beat_q);
               mem_rd_wr    = is_store(op_q) ? SB : LBU;
               mem_din[7:0] = wbyte;
            end else begin
               mem_addr  = addr_q;
               mem_rd_wr = op_q;
               mem_din   = wdata_q;
            end
            if (last_beat) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, beat counter, load assembly and response data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= LW;
         addr_q      <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         rdata_q     <= '0;
         split_q     <= 1'b0;
         beat_q      <= 2'd0;
         last_beat_q <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op_n;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  split_q <= req_misaligned;
                  beat_q  <= 2'd0;
                  asm_q   <= '0;
                  rdata_q <= '0;
                  if (!req_misaligned) begin
                     last_beat_q <= 2'd0;
                  end else if (is_word(req_op_n)) begin
                     last_beat_q <= 2'd3;
                  end else begin
                     last_beat_q <= 2'd1;
                  end
               end
            end
            BEAT: begin
               if (split_q && !is_store(op_q)) begin
                  asm_q <= assembled;
               end
               if (last_beat) begin
                  rdata_q <= final_rdata;
                  beat_q  <= 2'd0;
               end else begin
                  beat_q <= beat_q + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;

   // Trap flag: set when a misaligned request is accepted, cleared when the
   // response is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         err_q <= req_misaligned;
      end else if (state == RESP && rsp_ready) begin
         err_q <= 1'b0;
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign rsp_rdata = rdata_q;

endmodule
